// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner selection and output-enable sequencing for a shared tri-state bus.
// A dead interval with all enables low separates consecutive ownerships.
module tristate_bus_arbiter #(
  parameter int unsigned N          = 2,
  parameter int unsigned TURNAROUND = 1,
  parameter int unsigned MAX_HOLD   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [N-1:0]         oe,
  output logic                 busy,
  output logic [$clog2(N)-1:0] owner
);

  localparam int unsigned OW = $clog2(N);
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam int unsigned TW = $clog2(TURNAROUND + 1);

  localparam logic [HW-1:0] HoldMax = HW'(MAX_HOLD);
  localparam logic [TW-1:0] TurnLen = TW'(TURNAROUND);
  localparam logic [OW-1:0] LastIdx = OW'(N - 1);
  localparam logic [OW:0]   NumReq  = (OW + 1)'(N);

  typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_e;

  state_e        state_q, state_d;
  logic [OW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [OW-1:0] owner_q, owner_d;
  logic          busy_q;

  logic          win_valid;
  logic [OW-1:0] win_idx;
  logic [OW:0]   scan_sum;
  logic [OW-1:0] scan_idx;

  // Scan from ptr upward with wrap; the first requester found wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      scan_sum = {1'b0, ptr_q} + (OW + 1)'(i);
      if (scan_sum >= NumReq) begin
        scan_sum = scan_sum - NumReq;
      end
      scan_idx = scan_sum[OW-1:0];
      if (!win_valid && req[scan_idx]) begin
        win_valid = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hcnt_d  = hcnt_q;
    tcnt_d  = tcnt_q;
    grant_d = grant_q;
    owner_d = owner_q;
    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          owner_d          = win_idx;
          hcnt_d           = HW'(1);
          state_d          = StGrant;
        end
      end
      StGrant: begin
        // A request drop and hold expiry on the same edge collapse into one release.
        if (!req[owner_q] || (hcnt_q == HoldMax)) begin
          grant_d = '0;
          ptr_d   = (owner_q == LastIdx) ? '0 : owner_q + OW'(1);
          tcnt_d  = TW'(1);
          state_d = StTurn;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      StTurn: begin
        if (tcnt_q == TurnLen) begin
          if (win_valid) begin
            grant_d          = '0;
            grant_d[win_idx] = 1'b1;
            owner_d          = win_idx;
            hcnt_d           = HW'(1);
            state_d          = StGrant;
          end else begin
            state_d = StIdle;
          end
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      hcnt_q  <= '0;
      tcnt_q  <= '0;
      grant_q <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hcnt_q  <= hcnt_d;
      tcnt_q  <= tcnt_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      busy_q  <= |grant_d;
    end
  end

  assign grant = grant_q;
  assign oe    = grant_q;
  assign busy  = busy_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Bench for tristate_bus_arbiter: two configurations checked every cycle against an
// ownership-level model, plus literal grant sequences for the directed scenarios.
module tb_tristate_bus_arbiter;

  logic       clk;
  logic       a_rst, b_rst;
  logic [1:0] a_req, a_grant, a_oe;
  logic [2:0] b_req, b_grant, b_oe;
  logic       a_busy, b_busy;
  logic       a_owner;
  logic [1:0] b_owner;

  int n_checks = 0;
  int n_fail   = 0;

  tristate_bus_arbiter #(.N(2), .TURNAROUND(1), .MAX_HOLD(4)) dut_a (
    .clk  (clk),
    .rst  (a_rst),
    .req  (a_req),
    .grant(a_grant),
    .oe   (a_oe),
    .busy (a_busy),
    .owner(a_owner)
  );

  tristate_bus_arbiter #(.N(3), .TURNAROUND(2), .MAX_HOLD(4)) dut_b (
    .clk  (clk),
    .rst  (b_rst),
    .req  (b_req),
    .grant(b_grant),
    .oe   (b_oe),
    .busy (b_busy),
    .owner(b_owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state: who owns the bus (-1 for nobody), how long, and the dead cycles left.
  typedef struct {
    int own;
    int last;
    int held;
    int dead;
    int ptr;
  } mstate_t;

  mstate_t ma = '{own: -1, last: 0, held: 0, dead: 0, ptr: 0};
  mstate_t mb = '{own: -1, last: 0, held: 0, dead: 0, ptr: 0};

  function automatic bit rbit(input logic [7:0] r, input int k);
    return r[3'(k)];
  endfunction

  function automatic mstate_t mstep(input mstate_t s, input logic [7:0] r, input logic rs,
                                    input int n, input int ta, input int mh);
    mstate_t t;
    bit      arb;
    t   = s;
    arb = 1'b0;
    if (rs) begin
      t.own  = -1;
      t.last = 0;
      t.held = 0;
      t.dead = 0;
      t.ptr  = 0;
    end else begin
      if (t.own >= 0) begin
        if (!rbit(r, t.own) || t.held == mh) begin
          t.ptr  = (t.own + 1) % n;
          t.own  = -1;
          t.dead = ta;
        end else begin
          t.held = t.held + 1;
        end
      end else if (t.dead > 0) begin
        t.dead = t.dead - 1;
        arb    = (t.dead == 0);
      end else begin
        arb = 1'b1;
      end
      if (arb) begin
        for (int i = 0; i < n; i++) begin
          if (t.own < 0 && rbit(r, (t.ptr + i) % n)) begin
            t.own  = (t.ptr + i) % n;
            t.last = t.own;
            t.held = 1;
          end
        end
      end
    end
    return t;
  endfunction

  function automatic logic [7:0] mgrant(input mstate_t s);
    logic [7:0] one;
    one = 8'(1);
    return (s.own >= 0) ? (one << s.own) : 8'(0);
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      ma = mstep(ma, 8'(a_req), a_rst, 2, 1, 4);
      mb = mstep(mb, 8'(b_req), b_rst, 3, 2, 4);
    end
  end

  // Per-cycle comparison against the model plus bus-safety properties.
  initial begin
    logic [2:0] a_prev, b_prev;
    a_prev = '0;
    b_prev = '0;
    forever begin
      @(posedge clk);
      #1;
      chk("a_grant", 8'(a_grant), mgrant(ma));
      chk("a_oe", 8'(a_oe), mgrant(ma));
      chk("a_busy", 8'(a_busy), 8'(ma.own >= 0));
      chk("a_owner", 8'(a_owner), 8'(ma.last));
      chk("a_no_direct_switch", 8'(a_oe != 0 && a_prev != 0 && 3'(a_oe) != a_prev), 8'(0));
      chk("b_grant", 8'(b_grant), mgrant(mb));
      chk("b_oe", 8'(b_oe), mgrant(mb));
      chk("b_busy", 8'(b_busy), 8'(mb.own >= 0));
      chk("b_owner", 8'(b_owner), 8'(mb.last));
      chk("b_onehot", 8'($countones(b_oe) <= 1), 8'(1));
      chk("b_no_direct_switch", 8'(b_oe != 0 && b_prev != 0 && b_oe != b_prev), 8'(0));
      a_prev = 3'(a_oe);
      b_prev = b_oe;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] seq3 [14];
  logic [1:0] seq4 [14];
  logic [2:0] seq6 [16];
  logic [1:0] pat_a_req [9];
  int         pat_a_len [9];
  logic [2:0] pat_b_req [7];
  int         pat_b_len [7];

  initial begin
    int own6;
    seq3 = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00,
             2'b01, 2'b01, 2'b01, 2'b01};
    seq4 = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
             2'b01, 2'b01, 2'b01, 2'b01};
    seq6 = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b100, 3'b100, 3'b100,
             3'b100, 3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b001};
    pat_a_req = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b11, 2'b10, 2'b01, 2'b10, 2'b11};
    pat_a_len = '{3, 7, 2, 3, 12, 6, 1, 1, 5};
    pat_b_req = '{3'b111, 3'b010, 3'b110, 3'b011, 3'b000, 3'b100, 3'b111};
    pat_b_len = '{20, 6, 9, 4, 3, 10, 7};

    a_rst = 1'b1;
    a_req = 2'b11;
    b_rst = 1'b1;
    b_req = 3'b000;

    // Reset held two cycles with both requests high.
    for (int c = 0; c < 2; c++) begin
      step();
      chk("s1_grant", 8'(a_grant), 8'h00);
      chk("s1_oe", 8'(a_oe), 8'h00);
      chk("s1_busy", 8'(a_busy), 8'h00);
      chk("s1_owner", 8'(a_owner), 8'h00);
    end
    a_rst = 1'b0;

    // Contention: first grant right after reset, then alternate with a dead cycle.
    for (int c = 0; c < 14; c++) begin
      step();
      chk("s3_grant", 8'(a_grant), 8'(seq3[c]));
    end

    a_rst = 1'b1;
    a_req = 2'b00;
    step();
    a_rst = 1'b0;
    a_req = 2'b01;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("s2_grant", 8'(a_grant), 8'h01);
    end
    a_req = 2'b00;
    for (int c = 0; c < 2; c++) begin
      step();
      chk("s2_release", 8'(a_oe), 8'h00);
    end

    // Lone requester is forcibly released and re-granted.
    a_req = 2'b01;
    for (int c = 0; c < 14; c++) begin
      step();
      chk("s4_grant", 8'(a_grant), 8'(seq4[c]));
      chk("s4_owner", 8'(a_owner), 8'h00);
    end

    a_rst = 1'b1;
    a_req = 2'b00;
    step();
    a_rst = 1'b0;
    a_req = 2'b10;
    step();
    chk("s5_first", 8'(a_grant), 8'h02);
    step();
    chk("s5_second", 8'(a_grant), 8'h02);
    a_rst = 1'b1;
    step();
    chk("s5_oe_drop", 8'(a_oe), 8'h00);
    chk("s5_owner_rst", 8'(a_owner), 8'h00);
    a_rst = 1'b0;
    a_req = 2'b11;
    step();
    chk("s5_ptr_rst", 8'(a_grant), 8'h01);

    for (int p = 0; p < 9; p++) begin
      a_req = pat_a_req[p];
      for (int c = 0; c < pat_a_len[p]; c++) step();
    end

    // Fairness and wrap with N=3.
    b_rst = 1'b0;
    b_req = 3'b101;
    own6  = 0;
    for (int c = 0; c < 16; c++) begin
      step();
      if (seq6[c] == 3'b100) own6 = 2;
      if (seq6[c] == 3'b001) own6 = 0;
      chk("s6_grant", 8'(b_grant), 8'(seq6[c]));
      chk("s6_owner", 8'(b_owner), 8'(own6));
    end

    for (int p = 0; p < 7; p++) begin
      b_req = pat_b_req[p];
      for (int c = 0; c < pat_b_len[p]; c++) step();
    end
    // Reset landing in the middle of a dead interval.
    b_rst = 1'b1;
    step();
    chk("s6_rst_turn", 8'(b_oe), 8'h00);
    b_rst = 1'b0;
    for (int c = 0; c < 6; c++) step();

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
